// File: rtl/pc_gen.sv
// Program counter generator: sequential, redirect and trap next-PC selection,
// with stall-deferred events held in a one-entry pending register.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h80000000),
    parameter int              STEP         = 4,
    parameter int              ALIGN_BITS   = 2,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_target,
    output logic [XLEN-1:0]  pc_out,
    output logic             pending,
    output logic             misalign_err,
    output logic [CNT_W-1:0] advance_count
);

    localparam logic [XLEN-1:0] ALIGN_MASK =
        ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

    typedef enum logic {RUN, HOLD} state_t;

    state_t            state, state_n;
    logic              hold_trap, hold_trap_n;
    logic [XLEN-1:0]   hold_tgt, hold_tgt_n;
    logic [XLEN-1:0]   pc_n;
    logic              mis_n;

    logic              redir_ok;
    logic              take_new;
    logic [XLEN-1:0]   raw_tgt;

    // A redirect may not displace a trap that is already being held.
    assign redir_ok = redirect_valid && !(state == HOLD && hold_trap);
    assign take_new = trap_valid || redir_ok;
    assign raw_tgt  = trap_valid ? trap_target : redirect_target;
    assign pending  = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            hold_trap     <= 1'b0;
            hold_tgt      <= '0;
            pc_out        <= RESET_VECTOR;
            misalign_err  <= 1'b0;
            advance_count <= '0;
        end else begin
            state        <= state_n;
            hold_trap    <= hold_trap_n;
            hold_tgt     <= hold_tgt_n;
            pc_out       <= pc_n;
            misalign_err <= mis_n;
            if (!stall) begin
                advance_count <= advance_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_n     = state;
        hold_trap_n = hold_trap;
        hold_tgt_n  = hold_tgt;
        if (stall) begin
            if (take_new) begin
                state_n     = HOLD;
                hold_trap_n = trap_valid;
                hold_tgt_n  = raw_tgt & ALIGN_MASK;
            end
        end else begin
            state_n     = RUN;
            hold_trap_n = 1'b0;
            hold_tgt_n  = '0;
        end
    end

    always_comb begin
        pc_n  = pc_out;
        mis_n = take_new && (|(raw_tgt & ~ALIGN_MASK));
        if (!stall) begin
            if (take_new) begin
                pc_n = raw_tgt & ALIGN_MASK;
            end else if (state == HOLD) begin
                pc_n = hold_tgt;
            end else begin
                pc_n = pc_out + XLEN'(STEP);
            end
        end
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, meaning PC width in bits.
REQ-002 The block SHALL expose parameter RESET_VECTOR, default 32'h80000000, meaning the PC value loaded on reset.
REQ-003 The block SHALL expose parameter STEP, default 4, meaning the sequential PC increment.
REQ-004 The block SHALL expose parameter ALIGN_BITS, default 2, meaning the number of PC LSBs that must be zero.
REQ-005 The block SHALL expose parameter CNT_W, default 16, meaning the advance-counter width.
REQ-006 Port: clk  input  1  single clock; all state updates on posedge.
REQ-007 Port: rst  input  1  reset, synchronous, active-high.
REQ-008 Port: stall  input  1  hold PC this cycle.
REQ-009 Port: redirect_valid  input  1  branch/jump redirect request.
REQ-010 Port: redirect_target  input  XLEN  redirect destination.
REQ-011 Port: trap_valid  input  1  trap request.
REQ-012 Port: trap_target  input  XLEN  trap handler address.
REQ-013 Port: pc_out  output  XLEN  current PC, registered.
REQ-014 Port: pending  output  1  registered; high while a deferred redirect/trap is held.
REQ-015 Port: misalign_err  output  1  registered one-cycle pulse on misaligned target acceptance.
REQ-016 Port: advance_count  output  CNT_W  registered count of cycles in which pc_out was updated.

Function
REQ-017 Next-PC priority SHALL be: trap > redirect > pending > sequential (pc_out + STEP).
REQ-018 Sequential increment SHALL wrap modulo 2^XLEN (0xFFFFFFFC + 4 -> 0x00000000).
REQ-019 When stall=0, pc_out SHALL update on the next posedge (1-cycle latency) to the selected next-PC.
REQ-020 When stall=1, pc_out SHALL hold its value.
REQ-021 States: RUN (pending=0) and HOLD (pending=1); pending reg holds target plus kind (TRAP/REDIRECT).
REQ-022 RUN -> HOLD when stall=1 and trap_valid or redirect_valid; captured kind/target per REQ-017.
REQ-023 In HOLD with stall=1: a new trap SHALL overwrite any held event; a new redirect SHALL overwrite a held redirect but SHALL NOT overwrite a held trap.
REQ-024 HOLD -> RUN when stall=0; pc_out loads the new trap/redirect if one is present that cycle and REQ-023 permits it to override, else the held target.
REQ-025 Any accepted target (trap, redirect, or pending) SHALL have its ALIGN_BITS LSBs forced to zero before loading or capture.
REQ-026 misalign_err SHALL pulse high for one cycle after a cycle in which a target with nonzero ALIGN_BITS LSBs is captured or loaded; otherwise 0.
REQ-027 advance_count SHALL increment by 1 on every posedge where stall=0 and rst=0, wrapping modulo 2^CNT_W.
REQ-028 When ALIGN_BITS=0, no masking SHALL occur and misalign_err SHALL remain 0.

Reset
REQ-029 On posedge with rst=1: pc_out=RESET_VECTOR, pending=0, held event cleared, misalign_err=0, advance_count=0; rst overrides stall, trap and redirect.
REQ-030 Reset asserted while in HOLD SHALL discard the held event; no deferred load occurs after rst deasserts.

Verification
REQ-031 rst=1 one cycle, then stall=0 for 3 cycles -> pc_out 0x80000000, 0x80000004, 0x80000008, 0x8000000C; advance_count=3.
REQ-032 redirect_valid=1, target 0x80000100, trap_valid=1, target 0x80000200, same cycle, stall=0 -> pc_out=0x80000200 next cycle, pending=0.
REQ-033 stall=1, redirect to 0x80000040 -> pending=1, pc_out held; next cycle stall=1, trap to 0x80000300 -> held trap; next stall=1, redirect 0x80000500 -> still trap; stall=0 -> pc_out=0x80000300, pending=0.
REQ-034 redirect to 0x80000102, stall=0 -> pc_out=0x80000100, misalign_err=1 for exactly one cycle.
REQ-035 Load pc_out=0xFFFFFFFC via redirect, stall=0 next cycle -> pc_out=0x00000000; drive advance_count to 0xFFFF then one more advance -> 0x0000.
REQ-036 In HOLD (pending=1), assert rst for one cycle -> pc_out=0x80000000, pending=0, next non-stalled cycle pc_out=0x80000004.
